regfile_8x64: RTL and testbench
===============================

Name: regfile_8x64

Overview:
- Synchronous write-enable register file: 8 registers of 64 bits each.
- Internally a one-hot address decoder (enable + select) drives per-register load strobes on parallel-load registers.
- All registers are exposed at once on one flat 512-bit read bus; there is no read addressing.
- Used as a bulk state store where downstream logic consumes every register at once.

Parameters:
- DW, 64, data width of each register.
- AW, 3, select width; register count N = 2**AW = 8; q width = N*DW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  reset, synchronous, active-high. The name follows codebase convention; despite the _b suffix, 1 = reset.
- we  input  1  write enable.
- s  input  AW (3)  write register index, 0..7.
- d  input  DW (64)  write data.
- q  output  N*DW (512)  concatenated contents of all registers.

Behaviour:
- Storage: registers R0..R7, each DW bits.
- Output mapping, most significant first: Ri occupies q[N*DW-1-i*DW -: DW].
  - R0 is at q[511:448].
  - R1 is at q[447:384].
  - R7 is at q[63:0].
- Decoder: combinational, one-hot, N outputs. Output i = we AND (s == i). All outputs are 0 when we = 0.
- At each rising clk edge, priority order:
  1. rst_b = 1: every Ri <= 0, regardless of we, s or d.
  2. Else, if we = 1: R[s] <= d. All other registers hold.
  3. Else: all registers hold.
- Register sub-unit: inputs clr (synchronous clear) and ld (load strobe).
  - Priority within the sub-unit: reset > clr > ld > hold.
  - In this block clr is tied to 0.
  - Each register's ld comes from its own decoder output. Exactly one register can load per cycle; sharing a single strobe across registers is a defect.
- Latency: a write lands at the edge where it is sampled. q shows the new value right after that edge, so it is visible in the following cycle. There is no combinational path from d to q.
- Read: q is purely registered and always reflects all N registers at once. No read-during-write bypass.
- Reset value: q = 0 (all 512 bits).
- Reset asserted mid-operation: clears every register at the next edge. Any write presented in the same cycle is discarded.
- Reset release: the first edge with rst_b = 0 and we = 1 performs a write.
- Repeated writes to the same index on consecutive edges: the last write wins and the previous value is overwritten.
- s is fully decoded; every 3-bit value is valid, so there is no out-of-range case.
- X/unknown on s while we = 0 must not corrupt any register.

Test Plan:
- Reset: rst_b = 1 for one edge with we = 1, s = 3, d = 64'hFFFF_FFFF_FFFF_FFFF -> q = 512'h0 after the edge.
- Write each index exactly once: write d = 64'h1111_1111_1111_1111 * (i+1) to index i, for i = 0..7.
  - After each edge, only slice i changes.
  - Final: q[511:448] = 64'h1111_1111_1111_1111 and q[63:0] = 64'h8888_8888_8888_8888.
  - This catches shared or mis-indexed load strobes.
- Write disable: after the fill, set we = 0 with s = 2 and d = 64'hDEAD_BEEF_0000_0001 for 1 edge -> q unchanged.
- Overwrite: write index 5 with 64'hA5A5... and then 64'h5A5A... on consecutive edges -> q[191:128] = 64'h5A5A_5A5A_5A5A_5A5A; other slices unchanged.
- Reset mid-stream: with registers filled, assert rst_b = 1 together with we = 1, s = 0, d = 64'h1234 -> q = 0 after the edge. Next edge with rst_b = 0 and the same write -> q[511:448] = 64'h1234 and all other slices = 0.
- Randomized: 13 cycles of random s/d, we = 1 except cycle 6 -> compare q after every edge against a reference model of 8×64 registers.

Source files
------------

// File: rtl/regfile_8x64_if.sv
//------------------------------------------------------------------------------
// regfile_8x64_if : write port and flat read bus of the 8x64 register file
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_8x64_if #(
   parameter int DW = 64,
   parameter int AW = 3
);
   localparam int N = 2 ** AW;

   logic              we;
   logic [AW-1:0]     s;
   logic [DW-1:0]     d;
   logic [N*DW-1:0]   q;

   modport master (output we, output s, output d, input q);
   modport slave  (input we, input s, input d, output q);
endinterface

`default_nettype wire

// File: rtl/regfile_8x64.sv
//------------------------------------------------------------------------------
// regfile_8x64 : 8 x 64-bit write-enable register file, all registers on q
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_8x64_reg #(
   parameter int DW = 64
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          clr,
   input  wire logic          ld,
   input  wire logic [DW-1:0] d,
   output logic      [DW-1:0] q
);
   logic [DW-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= d;
      end
   end

   assign q = r_q;
endmodule

module regfile_8x64 #(
   parameter int DW = 64,
   parameter int AW = 3
) (
   input  wire logic       clk,
   input  wire logic       rst_b,
   regfile_8x64_if.slave   bus
);
   localparam int N = 2 ** AW;

   logic [N-1:0]    w_ld;
   logic [N*DW-1:0] w_q;

   // Each register gets its own decoded strobe; register 0 sits at the top of q.
   for (genvar i = 0; i < N; i++) begin : g_reg
      assign w_ld[i] = bus.we && (bus.s == AW'(i));

      regfile_8x64_reg #(
         .DW  (DW)
      ) u_reg (
         .clk (clk),
         .rst (rst_b),
         .clr (1'b0),
         .ld  (w_ld[i]),
         .d   (bus.d),
         .q   (w_q[N*DW-1-i*DW -: DW])
      );
   end

   assign bus.q = w_q;
endmodule

`default_nettype wire

// File: tb/tb_regfile_8x64.sv
//------------------------------------------------------------------------------
// tb_regfile_8x64 : directed and random stimulus against an array model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_8x64;
   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   regfile_8x64_if #(.DW(64), .AW(3)) bus ();

   regfile_8x64 #(.DW(64), .AW(3)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   logic [63:0]  mdl [8];
   logic         model_ok = 1'b0;
   int           n_chk = 0;
   int           n_pass = 0;
   logic [511:0] snap;

   function automatic logic [511:0] model_q();
      logic [511:0] v;
      for (int i = 0; i < 8; i++) v[511-64*i -: 64] = mdl[i];
      return v;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // Drive one cycle, then apply the same transaction to the model at the edge.
   task automatic step(input logic r, input logic w, input logic [2:0] sel, input logic [63:0] dat);
      rst_b  = r;
      bus.we = w;
      bus.s  = sel;
      bus.d  = dat;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 8; i++) mdl[i] = 64'h0;
         model_ok = 1'b1;
      end else if (w) begin
         mdl[sel] = dat;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (model_ok) check("model", bus.q, model_q());
   end

   initial begin
      logic [63:0] pat;
      rst_b  = 1'b1;
      bus.we = 1'b0;
      bus.s  = 3'd0;
      bus.d  = 64'h0;

      step(1'b1, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      check("reset", bus.q, 512'h0);

      for (int i = 0; i < 8; i++) begin
         pat = 64'h1111_1111_1111_1111 * (i + 1);
         step(1'b0, 1'b1, 3'(i), pat);
         check64("fill_slice", bus.q[511-64*i -: 64], pat);
      end
      check64("fill_r0", bus.q[511:448], 64'h1111_1111_1111_1111);
      check64("fill_r7", bus.q[63:0],    64'h8888_8888_8888_8888);

      snap = bus.q;
      step(1'b0, 1'b0, 3'd2, 64'hDEAD_BEEF_0000_0001);
      check("we_low", bus.q, snap);

      step(1'b0, 1'b0, 3'bxxx, 64'hDEAD_BEEF_0000_0002);
      check("s_x_we_low", bus.q, snap);

      step(1'b0, 1'b1, 3'd5, 64'hA5A5_A5A5_A5A5_A5A5);
      step(1'b0, 1'b1, 3'd5, 64'h5A5A_5A5A_5A5A_5A5A);
      check64("overwrite_r5", bus.q[191:128], 64'h5A5A_5A5A_5A5A_5A5A);
      check64("overwrite_r4", bus.q[255:192], 64'h5555_5555_5555_5555);
      check64("overwrite_r6", bus.q[127:64],  64'h7777_7777_7777_7777);

      step(1'b1, 1'b1, 3'd0, 64'h1234);
      check("mid_reset", bus.q, 512'h0);
      step(1'b0, 1'b1, 3'd0, 64'h1234);
      check("post_reset_write", bus.q, {64'h1234, 448'h0});

      for (int k = 0; k < 13; k++) begin
         step(1'b0, (k != 5), 3'($urandom_range(0, 7)), {$urandom, $urandom});
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
